// File: rtl/cpu_ram_loader_if.sv
// Bus bundle between the boot loader, the program ROM and the CPU initialisation inputs.
// The master modport is the loader side; the slave modport is the ROM/CPU/host side.
interface cpu_ram_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              loading_ram;
    logic              set_mar_init;
    logic [ADDR_W-1:0] addr_init;
    logic              set_ram_init;
    logic [DATA_W-1:0] instr_from_rom;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   load_count;

    modport master (
        input  start, rom_data,
        output rom_addr, loading_ram, set_mar_init, addr_init, set_ram_init,
               instr_from_rom, cpu_reset, busy, done, load_count
    );

    modport slave (
        output start, rom_data,
        input  rom_addr, loading_ram, set_mar_init, addr_init, set_ram_init,
               instr_from_rom, cpu_reset, busy, done, load_count
    );
endinterface

// File: rtl/cpu_ram_loader.sv
// Self-timed boot sequencer: copies LOAD_LEN ROM words into CPU RAM via MAR/RAM set pulses,
// holding the CPU in reset until the whole image has been written.
module cpu_ram_loader #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                LOAD_LEN  = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ROM_LAT   = 1,
    parameter int                PULSE_W   = 2
) (
    input  logic             in_clk,
    input  logic             reset,
    cpu_ram_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP1, S_FETCH, S_DATA, S_GAP2, S_DONE
    } state_t;

    localparam int CNT_MAX = (PULSE_W > ROM_LAT) ? PULSE_W : ROM_LAT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(ROM_LAT - 1);
    localparam logic [ADDR_W:0]  LAST_IDX   = (ADDR_W+1)'(LOAD_LEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] addr_init_q, addr_init_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              loading_q, loading_d;
    logic              set_mar_q, set_mar_d;
    logic              set_ram_q, set_ram_d;
    logic              done_q, done_d;
    logic              cpu_reset_q, cpu_reset_d;

    logic accept;
    logic last_word;

    // rom_addr doubles as the word index i.
    assign accept    = (state_q == S_IDLE) && bus.start;
    assign last_word = ({1'b0, rom_addr_q} == LAST_IDX);

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rom_addr_q   <= '0;
            addr_init_q  <= BASE_ADDR;
            instr_q      <= '0;
            load_count_q <= '0;
            loading_q    <= 1'b0;
            set_mar_q    <= 1'b0;
            set_ram_q    <= 1'b0;
            done_q       <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rom_addr_q   <= rom_addr_d;
            addr_init_q  <= addr_init_d;
            instr_q      <= instr_d;
            load_count_q <= load_count_d;
            loading_q    <= loading_d;
            set_mar_q    <= set_mar_d;
            set_ram_q    <= set_ram_d;
            done_q       <= done_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_ADDR;
            S_ADDR:  if (cnt_q == PULSE_LAST) state_d = S_GAP1;
            S_GAP1:  state_d = S_FETCH;
            S_FETCH: if (cnt_q == LAT_LAST) state_d = S_DATA;
            S_DATA:  if (cnt_q == PULSE_LAST) state_d = S_GAP2;
            S_GAP2:  state_d = last_word ? S_DONE : S_ADDR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Dwell counter restarts on every state change.
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        rom_addr_d   = rom_addr_q;
        addr_init_d  = addr_init_q;
        instr_d      = instr_q;
        load_count_d = load_count_q;
        done_d       = done_q;
        cpu_reset_d  = cpu_reset_q;
        if (accept) begin
            rom_addr_d   = '0;
            addr_init_d  = BASE_ADDR;
            load_count_d = '0;
            done_d       = 1'b0;
            cpu_reset_d  = 1'b1;
        end else begin
            if (state_q == S_GAP2) begin
                load_count_d = load_count_q + 1'b1;
                if (!last_word) begin
                    rom_addr_d  = rom_addr_q + 1'b1;
                    addr_init_d = addr_init_q + 1'b1;
                end
            end
            if ((state_q == S_FETCH) && (cnt_q == LAT_LAST)) instr_d = bus.rom_data;
            if (state_q == S_DONE) done_d = 1'b1;
            // CPU is released the cycle after done first shows.
            if (done_q) cpu_reset_d = 1'b0;
        end
        // Pulses are decoded from the next state so they are registered, glitch-free outputs.
        loading_d = (state_d != S_IDLE) && (state_d != S_DONE);
        set_mar_d = (state_d == S_ADDR);
        set_ram_d = (state_d == S_DATA);
    end

    assign bus.rom_addr       = rom_addr_q;
    assign bus.addr_init      = addr_init_q;
    assign bus.instr_from_rom = instr_q;
    assign bus.load_count     = load_count_q;
    assign bus.loading_ram    = loading_q;
    assign bus.busy           = loading_q;
    assign bus.set_mar_init   = set_mar_q;
    assign bus.set_ram_init   = set_ram_q;
    assign bus.done           = done_q;
    assign bus.cpu_reset      = cpu_reset_q;
endmodule

// File: tb/tb_cpu_ram_loader.sv
// Scoreboard bench for cpu_ram_loader: a stimulus process predicts every pulse, load boundary
// and flag transition from the timing rules; a monitor pops and compares as the DUT shows them.
module tb_cpu_ram_loader;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int LEN = 256;
    localparam int LAT = 3;
    localparam int PW  = 2;
    localparam logic [AW-1:0] BASE = 8'hFE;
    localparam int W   = 2 * PW + LAT + 2;
    localparam int LW  = LEN * W;

    typedef struct {
        int            e;
        logic [AW-1:0] a;
        logic [AW-1:0] ra;
        logic [DW-1:0] d;
    } ev_t;

    logic in_clk = 1'b0;
    logic reset;

    cpu_ram_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    cpu_ram_loader #(
        .DATA_W(DW), .ADDR_W(AW), .LOAD_LEN(LEN), .BASE_ADDR(BASE),
        .ROM_LAT(LAT), .PULSE_W(PW)
    ) dut (
        .in_clk(in_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 in_clk = ~in_clk;

    logic [DW-1:0] rom_mem [LEN];
    ev_t q_mar[$];
    ev_t q_ram[$];
    int  q_begin[$];
    int  q_end[$];
    int  q_done[$];
    int  q_crel[$];
    int  edge_n     = 0;
    int  checks     = 0;
    int  errors     = 0;
    int  busy_until = -1;   // last edge at which a start is still ignored
    int  last_s     = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endfunction

    initial forever begin
        @(posedge in_clk);
        edge_n++;
    end

    // ROM with ROM_LAT latency: the word is valid only once the address has been stable long enough.
    initial begin : rom_model
        logic [AW-1:0] last_a;
        int age;
        for (int k = 0; k < LEN; k++) rom_mem[k] = DW'($urandom);
        last_a = '1;
        age = 0;
        bus.rom_data = '0;
        forever begin
            @(negedge in_clk);
            if (bus.rom_addr !== last_a) begin
                age = 0;
                last_a = bus.rom_addr;
            end else if (age < 1000) begin
                age++;
            end
            if (age >= LAT) bus.rom_data = rom_mem[bus.rom_addr];
            else bus.rom_data = rom_mem[bus.rom_addr] ^ DW'(1 + $urandom_range(0, 254));
        end
    end

    initial begin : monitor
        logic p_busy, p_mar, p_ram, p_done, p_crst;
        int mar_run, ram_run, e;
        ev_t ev;
        p_busy = 0; p_mar = 0; p_ram = 0; p_done = 0; p_crst = 1;
        mar_run = 0; ram_run = 0;
        forever begin
            @(negedge in_clk or posedge reset);
            if (reset) begin
                q_mar.delete(); q_ram.delete(); q_begin.delete();
                q_end.delete(); q_done.delete(); q_crel.delete();
                p_busy = 0; p_mar = 0; p_ram = 0; p_done = 0; p_crst = 1;
                mar_run = 0; ram_run = 0;
            end else begin
                chk("busy_eq_loading", 64'(bus.busy), 64'(bus.loading_ram));
                chk("pulse_overlap", 64'(bus.set_mar_init & bus.set_ram_init), 0);
                chk("pulse_outside_load",
                    64'((bus.set_mar_init | bus.set_ram_init) & ~bus.loading_ram), 0);
                if (bus.busy && !p_busy) begin
                    if (q_begin.size() == 0) chk("unexpected_load_start", 1, 0);
                    else begin e = q_begin.pop_front(); chk("load_start_edge", 64'(edge_n), 64'(e)); end
                    chk("start_done_clear", 64'(bus.done), 0);
                    chk("start_cpu_reset", 64'(bus.cpu_reset), 1);
                    chk("start_load_count", 64'(bus.load_count), 0);
                end
                if (!bus.busy && p_busy) begin
                    if (q_end.size() == 0) chk("unexpected_load_end", 1, 0);
                    else begin e = q_end.pop_front(); chk("load_end_edge", 64'(edge_n), 64'(e)); end
                    chk("end_load_count", 64'(bus.load_count), 64'(LEN));
                end
                if (bus.done && !p_done) begin
                    if (q_done.size() == 0) chk("unexpected_done", 1, 0);
                    else begin e = q_done.pop_front(); chk("done_edge", 64'(edge_n), 64'(e)); end
                end
                if (!bus.cpu_reset && p_crst) begin
                    if (q_crel.size() == 0) chk("unexpected_cpu_release", 1, 0);
                    else begin e = q_crel.pop_front(); chk("cpu_release_edge", 64'(edge_n), 64'(e)); end
                end
                if (bus.set_mar_init && !p_mar) begin
                    if (q_mar.size() == 0) chk("unexpected_mar_pulse", 1, 0);
                    else begin
                        ev = q_mar.pop_front();
                        chk("mar_edge", 64'(edge_n), 64'(ev.e));
                        chk("mar_addr_init", 64'(bus.addr_init), 64'(ev.a));
                        chk("mar_rom_addr", 64'(bus.rom_addr), 64'(ev.ra));
                    end
                end
                if (bus.set_ram_init && !p_ram) begin
                    if (q_ram.size() == 0) chk("unexpected_ram_pulse", 1, 0);
                    else begin
                        ev = q_ram.pop_front();
                        $display("ram write edge=%0d addr=%02h data=%02h", edge_n, bus.addr_init,
                                 bus.instr_from_rom);
                        chk("ram_edge", 64'(edge_n), 64'(ev.e));
                        chk("ram_addr_init", 64'(bus.addr_init), 64'(ev.a));
                        chk("ram_data", 64'(bus.instr_from_rom), 64'(ev.d));
                    end
                end
                if (bus.set_mar_init) mar_run++;
                else if (p_mar) begin chk("mar_width", 64'(mar_run), 64'(PW)); mar_run = 0; end
                if (bus.set_ram_init) ram_run++;
                else if (p_ram) begin chk("ram_width", 64'(ram_run), 64'(PW)); ram_run = 0; end
                p_busy = bus.busy; p_mar = bus.set_mar_init; p_ram = bus.set_ram_init;
                p_done = bus.done; p_crst = bus.cpu_reset;
            end
        end
    end

    task automatic wait_until(input int e);
        while (edge_n < e) @(negedge in_clk);
    endtask

    // Called at a negedge: start is sampled at the next edge, and is accepted only when idle.
    task automatic try_start();
        int s;
        s = edge_n + 1;
        bus.start = 1'b1;
        if (s > busy_until) begin
            while (q_crel.size() > 0 && q_crel[$] >= s) void'(q_crel.pop_back());
            q_begin.push_back(s);
            for (int k = 0; k < LEN; k++) begin
                q_mar.push_back('{s + k * W, AW'(BASE + k), AW'(k), '0});
                q_ram.push_back('{s + k * W + PW + 1 + LAT, AW'(BASE + k), AW'(k), rom_mem[k]});
            end
            q_end.push_back(s + LW);
            q_done.push_back(s + LW + 1);
            q_crel.push_back(s + LW + 2);
            busy_until = s + LW + 1;
            last_s = s;
            $display("start accepted at edge %0d", s);
        end else begin
            $display("start ignored at edge %0d", s);
        end
        @(negedge in_clk);
        bus.start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 0);
        chk({tag, "_loading_ram"}, 64'(bus.loading_ram), 0);
        chk({tag, "_set_mar"}, 64'(bus.set_mar_init), 0);
        chk({tag, "_set_ram"}, 64'(bus.set_ram_init), 0);
        chk({tag, "_done"}, 64'(bus.done), 0);
        chk({tag, "_cpu_reset"}, 64'(bus.cpu_reset), 1);
        chk({tag, "_addr_init"}, 64'(bus.addr_init), 64'(BASE));
        chk({tag, "_rom_addr"}, 64'(bus.rom_addr), 0);
        chk({tag, "_instr"}, 64'(bus.instr_from_rom), 0);
        chk({tag, "_load_count"}, 64'(bus.load_count), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int s1, s2, s3;
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge in_clk);
        #2 reset = 1'b0;
        @(negedge in_clk);
        check_reset_values("por");

        // Load 1, with starts while busy and in the DONE cycle that must be ignored.
        try_start();
        s1 = last_s;
        wait_until(s1 + 9);
        try_start();
        wait_until(s1 + LW);
        try_start();

        // Reload after completion.
        wait_until(s1 + LW + 6);
        chk("idle_cpu_released", 64'(bus.cpu_reset), 0);
        chk("idle_done_sticky", 64'(bus.done), 1);
        chk("idle_load_count", 64'(bus.load_count), 64'(LEN));
        try_start();
        s2 = last_s;

        // Start on the first idle edge after DONE is accepted.
        wait_until(s2 + LW + 1);
        try_start();
        s3 = last_s;

        // Asynchronous reset during the DATA phase of word 2.
        wait_until(s3 + 2 * W + PW + 1 + LAT);
        chk("in_data_state_before_reset", 64'(bus.set_ram_init), 1);
        chk("word2_addr_before_reset", 64'(bus.addr_init), 64'(AW'(BASE + 2)));
        #2 reset = 1'b1;
        #1 check_reset_values("midload");
        @(posedge in_clk);
        #2 reset = 1'b0;
        busy_until = -1;
        repeat (20) @(negedge in_clk);
        chk("post_reset_idle_busy", 64'(bus.busy), 0);
        chk("post_reset_cpu_reset", 64'(bus.cpu_reset), 1);
        chk("post_reset_done", 64'(bus.done), 0);

        // Randomly timed starts, many landing while a load is in progress.
        repeat (10) begin
            repeat ($urandom_range(1, 700)) @(negedge in_clk);
            try_start();
        end

        wait_until(busy_until + 3);
        @(negedge in_clk);
        chk("final_done", 64'(bus.done), 1);
        chk("final_cpu_reset", 64'(bus.cpu_reset), 0);
        chk("final_busy", 64'(bus.busy), 0);
        chk("final_load_count", 64'(bus.load_count), 64'(LEN));
        chk("final_last_ram_addr", 64'(bus.addr_init), 64'(AW'(BASE + LEN - 1)));
        chk("pending_mar", 64'(q_mar.size()), 0);
        chk("pending_ram", 64'(q_ram.size()), 0);
        chk("pending_begin", 64'(q_begin.size()), 0);
        chk("pending_end", 64'(q_end.size()), 0);
        chk("pending_done", 64'(q_done.size()), 0);
        chk("pending_release", 64'(q_crel.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
